uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART serial transmitter, the transmit-side companion of the team's 8N1 UART receiver on the 12 MHz serial clock. It accepts bytes over a valid/ready handshake into a small FIFO. It serialises each byte LSB-first as a start bit, 8 data bits and a stop bit onto the TX pin, and signals per-frame completion. It is used with the receiver for loopback/mirror designs and host links.

Parameters:
UART_BAUD, 9600, line baud rate.
CLKS_PER_BIT, 12_000_000 / UART_BAUD (1250), SER_CLK cycles per bit. Must be >= 2; benches override it to 4.
FIFO_DEPTH, 4, holding FIFO entries; power of two, 2..16.

Ports:
SER_CLK  input  1  system/serial clock, 12 MHz; all logic on posedge.
RST  input  1  synchronous, active-high reset.
TX_DV  input  1  byte-valid strobe; TX_BYTE is captured on any cycle where TX_DV=1 and TX_READY=1.
TX_BYTE  input  8  byte to send.
TX_READY  output  1  FIFO not full.
TX_SERIAL  output  1  serial line out; idle high; registered.
TX_ACTIVE  output  1  high while a frame is on the line (START through STOP).
TX_DONE  output  1  one-cycle pulse at end of each frame's stop bit.
TX_OVF  output  1  one-cycle pulse when TX_DV=1 arrives while TX_READY=0; that byte is dropped.

Behaviour:
- Clock and reset: one clock, SER_CLK. Reset is synchronous and active-high (RST), sampled on the SER_CLK rising edge.
- Reset values:
  - TX_SERIAL=1, TX_ACTIVE=0, TX_DONE=0, TX_OVF=0, TX_READY=1.
  - FIFO empty; state IDLE; bit counter 0; clock counter 0.
- Reset mid-frame: applies on the next edge and aborts the frame. The line returns high immediately and all FIFO contents are discarded.
- FIFO:
  - TX_READY = (count != FIFO_DEPTH), driven combinationally from registered count.
  - Push when TX_DV & TX_READY.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - A push while full is refused even if a pop occurs that cycle. TX_OVF pulses for that cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - Count width is clog2(FIFO_DEPTH)+1.
- Clock counter: at least 32 bits, compared against CLKS_PER_BIT-1.
- FSM states: IDLE, START, DATA, STOP, CLEANUP; any other encoding goes to IDLE.
  - IDLE: TX_SERIAL=1, TX_ACTIVE=0. If the FIFO is non-empty, pop the head into a shift register, set TX_SERIAL<=0 and TX_ACTIVE<=1, and go to START.
  - START: hold 0 for CLKS_PER_BIT cycles, then drive bit 0 and go to DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit 7 has completed, drive 1 and go to STOP.
  - STOP: hold 1 for CLKS_PER_BIT cycles. Then TX_DONE<=1, TX_ACTIVE<=0, and go to CLEANUP.
  - CLEANUP: TX_DONE<=0, go to IDLE.
- Latency: a byte pushed at edge E0 into an empty, idle block drives the start bit from edge E2.
- Frame and back-to-back spacing:
  - Frame length is 10*CLKS_PER_BIT cycles, from the start-bit falling edge to the end of the stop bit.
  - Back-to-back FIFO bytes add exactly 2 extra high cycles (CLEANUP, IDLE) between frames.
- TX_BYTE changes after the push do not affect the frame in flight.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP, held CLKS_PER_BIT cycles.
  - Parity bit = XOR of the 8 data bits (even parity), or its inverse when input PARITY_ODD=1.
  - PARITY_ODD is an extra 1-bit input, sampled at pop.
  - Frame length becomes 11*CLKS_PER_BIT.
- Undefined: no PARITY state and no PARITY_ODD port; 8N1 only.

Test Plan:
- Reset then idle 100 cycles (CLKS_PER_BIT=4) -> TX_SERIAL=1, TX_READY=1, TX_ACTIVE=0, TX_DONE/TX_OVF never pulse.
- Push 0xA5 once -> start bit from 2 cycles after push. Line bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles. TX_DONE single pulse at cycle 42 after push; the receiver in loopback reports RX_BYTE=0xA5.
- Push 0x00, 0xFF, 0x55, 0x3C on consecutive cycles -> all accepted. Four frames in order with 2-cycle gaps; four TX_DONE pulses; TX_READY deasserts only if the FIFO fills.
- Push 6 bytes on consecutive cycles with FIFO_DEPTH=4 -> first 5 accepted (one popped into the shifter at cycle 2). The 6th sees TX_READY=0 and TX_OVF pulses once; 5 frames sent.
- Assert RST during DATA bit 3 of 0x81 with 2 bytes queued -> next cycle TX_SERIAL=1, TX_ACTIVE=0, FIFO empty. No TX_DONE; no further frames.
- With UART_TX_PARITY_EN: send 0x07 with PARITY_ODD=0 -> parity bit 1, frame 44 cycles. With PARITY_ODD=1 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input into a small FIFO, serialised as 8N1 (LSB first).
// Optional parity bit between data and stop when UART_TX_PARITY_EN is defined (adds PARITY_ODD).
module uart_tx #(
  parameter int UART_BAUD    = 9600,
  parameter int CLKS_PER_BIT = 12_000_000 / UART_BAUD,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       SER_CLK,
  input  logic       RST,
  input  logic       TX_DV,
  input  logic [7:0] TX_BYTE,
`ifdef UART_TX_PARITY_EN
  input  logic       PARITY_ODD,
`endif
  output logic       TX_READY,
  output logic       TX_SERIAL,
  output logic       TX_ACTIVE,
  output logic       TX_DONE,
  output logic       TX_OVF
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [31:0]      BIT_LAST  = 32'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd3;
  localparam logic [2:0] S_CLEANUP = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY  = 3'd5;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             avail_q;
  logic             push, pop;
  logic [7:0]       head;

  // Serialiser state
  logic [2:0]  state_q, state_d;
  logic [31:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        serial_q, serial_d;
  logic        active_q, active_d;
  logic        done_q, done_d;
  logic        bit_end;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  assign TX_READY = (count_q != CNT_FULL);
  assign TX_OVF   = TX_DV & ~TX_READY;
  assign push     = TX_DV & TX_READY;
  assign pop      = (state_q == S_IDLE) & avail_q;
  assign head     = mem_q[rd_ptr_q];
  assign bit_end  = (clk_cnt_q == BIT_LAST);

  assign TX_SERIAL = serial_q;
  assign TX_ACTIVE = active_q;
  assign TX_DONE   = done_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    serial_d  = serial_q;
    active_d  = active_q;
    done_d    = done_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        serial_d  = 1'b1;
        active_d  = 1'b0;
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (avail_q) begin
          shift_d  = head;
          serial_d = 1'b0;
          active_d = 1'b1;
          state_d  = S_START;
`ifdef UART_TX_PARITY_EN
          parity_d = (^head) ^ PARITY_ODD;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          serial_d  = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          state_d   = S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 32'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            serial_d = parity_q;
            state_d  = S_PARITY;
`else
            serial_d = 1'b1;
            state_d  = S_STOP;
`endif
          end else begin
            // shift_q[0] already holds the next bit to send
            bit_idx_d = bit_idx_q + 3'd1;
            serial_d  = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 32'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          serial_d  = 1'b1;
          state_d   = S_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 32'd1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          done_d    = 1'b1;
          active_d  = 1'b0;
          state_d   = S_CLEANUP;
        end else begin
          clk_cnt_d = clk_cnt_q + 32'd1;
        end
      end
      S_CLEANUP: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        serial_d  = 1'b1;
        active_d  = 1'b0;
        done_d    = 1'b0;
        clk_cnt_d = '0;
      end
    endcase
  end

  // NOTE: the data array has no reset; only pointers and count define what is valid.
  always_ff @(posedge SER_CLK) begin
    if (push) mem_q[wr_ptr_q] <= TX_BYTE;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge SER_CLK) begin
    if (RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      avail_q   <= 1'b0;
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      // Lags count by one edge, so a byte pushed at edge E0 starts its frame from E2.
      avail_q   <= (count_q != '0);
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4): expected line, ACTIVE, DONE,
// READY and OVF come from a per-cycle frame schedule computed here from the pushed bytes.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FC = FB * CPB;

  logic       SER_CLK = 1'b0;
  logic       RST = 1'b1;
  logic       TX_DV = 1'b0;
  logic [7:0] TX_BYTE = 8'h00;
  logic       parity_odd = 1'b0;
  logic       TX_READY, TX_SERIAL, TX_ACTIVE, TX_DONE, TX_OVF;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] stim [$];
  logic [7:0] frames [$];
  int         starts [$];

  uart_tx #(
    .UART_BAUD   (9600),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .SER_CLK   (SER_CLK),
    .RST       (RST),
    .TX_DV     (TX_DV),
    .TX_BYTE   (TX_BYTE),
`ifdef UART_TX_PARITY_EN
    .PARITY_ODD(parity_odd),
`endif
    .TX_READY  (TX_READY),
    .TX_SERIAL (TX_SERIAL),
    .TX_ACTIVE (TX_ACTIVE),
    .TX_DONE   (TX_DONE),
    .TX_OVF    (TX_OVF)
  );

  always #5 SER_CLK = ~SER_CLK;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, required finish before time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (FB == 11 && j == 9) return (^b) ^ parity_odd;
    return 1'b1;
  endfunction

  // Expected outputs during the cycle following edge k of the current sequence.
  function automatic void exp_line(input int k, output logic ser, output logic act, output logic dn);
    ser = 1'b1;
    act = 1'b0;
    dn  = 1'b0;
    foreach (starts[i]) begin
      if (k >= starts[i] && k < starts[i] + FC) begin
        act = 1'b1;
        ser = frame_bit(frames[i], (k - starts[i]) / CPB);
      end
      if (k == starts[i] + FC) dn = 1'b1;
    end
  endfunction

  function automatic int seq_cycles(input int n);
    return 2 + (n - 1) * (FC + 2) + FC + 6;
  endfunction

  // Entered just after a rising edge; push stim[c] before edge c, check every cycle.
  task automatic run_seq(input int ncyc);
    int   cnt_m;
    int   nxt;
    logic dv, acc, pop;
    logic e_ser, e_act, e_dn;
    cnt_m = 0;
    frames.delete();
    starts.delete();
    for (int c = 0; c < ncyc; c++) begin
      dv      = (c < stim.size());
      TX_DV   = dv;
      TX_BYTE = dv ? stim[c] : (8'h5A ^ 8'(c));
      @(negedge SER_CLK);
      exp_line(c - 1, e_ser, e_act, e_dn);
      check($sformatf("serial@%0d", c - 1), 32'(TX_SERIAL), 32'(e_ser));
      check($sformatf("active@%0d", c - 1), 32'(TX_ACTIVE), 32'(e_act));
      check($sformatf("done@%0d", c - 1),   32'(TX_DONE),   32'(e_dn));
      check($sformatf("ready@%0d", c - 1),  32'(TX_READY),  32'(cnt_m != DEPTH));
      check($sformatf("ovf@%0d", c - 1),    32'(TX_OVF),    32'(dv && cnt_m == DEPTH));
      @(posedge SER_CLK);
      #1;
      acc = dv && (cnt_m != DEPTH);
      pop = 1'b0;
      foreach (starts[i]) if (starts[i] == c) pop = 1'b1;
      if (acc) begin
        frames.push_back(stim[c]);
        if (starts.size() == 0) begin
          starts.push_back(c + 2);
        end else begin
          nxt = starts[$] + FC + 2;
          starts.push_back((nxt > c + 2) ? nxt : c + 2);
        end
      end
      cnt_m = cnt_m + (acc ? 1 : 0) - (pop ? 1 : 0);
    end
    TX_DV = 1'b0;
  endtask

  initial begin
    int bad_ser, bad_rdy, bad_act, bad_dn, bad_ovf;

    // Reset and idle
    repeat (3) @(posedge SER_CLK);
    #1;
    RST = 1'b0;
    @(negedge SER_CLK);
    check("rst_serial", 32'(TX_SERIAL), 32'd1);
    check("rst_active", 32'(TX_ACTIVE), 32'd0);
    check("rst_done",   32'(TX_DONE),   32'd0);
    check("rst_ovf",    32'(TX_OVF),    32'd0);
    check("rst_ready",  32'(TX_READY),  32'd1);
    bad_ser = 0; bad_rdy = 0; bad_act = 0; bad_dn = 0; bad_ovf = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge SER_CLK);
      if (TX_SERIAL !== 1'b1) bad_ser++;
      if (TX_READY  !== 1'b1) bad_rdy++;
      if (TX_ACTIVE !== 1'b0) bad_act++;
      if (TX_DONE   !== 1'b0) bad_dn++;
      if (TX_OVF    !== 1'b0) bad_ovf++;
    end
    check("idle_serial_bad_cycles", 32'(bad_ser), 32'd0);
    check("idle_ready_bad_cycles",  32'(bad_rdy), 32'd0);
    check("idle_active_bad_cycles", 32'(bad_act), 32'd0);
    check("idle_done_pulses",       32'(bad_dn),  32'd0);
    check("idle_ovf_pulses",        32'(bad_ovf), 32'd0);
    @(posedge SER_CLK);
    #1;

    // Single byte
    stim = '{8'hA5};
    run_seq(seq_cycles(1));

    // Four back-to-back bytes, FIFO never fills
    stim = '{8'h00, 8'hFF, 8'h55, 8'h3C};
    run_seq(seq_cycles(4));

    // Six pushes: five accepted, sixth overflows
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h77};
    run_seq(seq_cycles(5));

    // Reset during data bit 3 of 0x81 with two bytes queued
    stim = '{8'h81, 8'h12, 8'h34};
    run_seq(2 + CPB * 4 + 2);
    RST = 1'b1;
    @(posedge SER_CLK);
    #1;
    RST = 1'b0;
    @(negedge SER_CLK);
    check("midrst_serial", 32'(TX_SERIAL), 32'd1);
    check("midrst_active", 32'(TX_ACTIVE), 32'd0);
    check("midrst_done",   32'(TX_DONE),   32'd0);
    check("midrst_ready",  32'(TX_READY),  32'd1);
    bad_ser = 0; bad_act = 0; bad_dn = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge SER_CLK);
      if (TX_SERIAL !== 1'b1) bad_ser++;
      if (TX_ACTIVE !== 1'b0) bad_act++;
      if (TX_DONE   !== 1'b0) bad_dn++;
    end
    check("postrst_serial_low_cycles", 32'(bad_ser), 32'd0);
    check("postrst_active_cycles",     32'(bad_act), 32'd0);
    check("postrst_done_pulses",       32'(bad_dn),  32'd0);
    @(posedge SER_CLK);
    #1;
    // Only this byte may appear; any stale queued byte would break the schedule
    stim = '{8'hC3};
    run_seq(seq_cycles(1) + FC);

`ifdef UART_TX_PARITY_EN
    parity_odd = 1'b0;
    stim = '{8'h07};
    run_seq(seq_cycles(1));
    parity_odd = 1'b1;
    stim = '{8'h07};
    run_seq(seq_cycles(1));
    parity_odd = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
